// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue
//
// Y86-64 fetch stage with a byte prefetch buffer. Aligned instruction-memory beats are streamed
// into the buffer, one variable-length instruction is extracted per decode handshake, the next
// PC is predicted (jxx/call taken), and redirects flush the buffer and restart fetch.
//
// Parameters
//   FETCH_BYTES  bytes per memory beat (power of 2, >= 2)
//   BUF_BYTES    prefetch buffer capacity (multiple of FETCH_BYTES, >= 16)
//   IMEM_SIZE    bytes of valid instruction memory; higher addresses are address errors
//   RESET_PC     PC loaded on reset
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   imem_req_valid/ready/addr   beat request channel (aligned addresses)
//   imem_rsp_valid/data         in-order response beats, lowest address in [7:0]
//   redirect_valid/pc           external flush and restart
//   out_valid/ready             instruction handshake towards decode
//   out_icode/ifun/rA/rB        instruction fields (rA/rB = 4'hF when absent)
//   out_valC/valP/predPC        constant, fall-through PC, predicted next PC
//   out_stat                    1 AOK, 2 HLT, 3 ADR, 4 INS

module y86_fetch_queue #(
    parameter int unsigned FETCH_BYTES = 8,
    parameter int unsigned BUF_BYTES   = 32,
    parameter int unsigned IMEM_SIZE   = 1024,
    parameter logic [63:0] RESET_PC    = 64'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [63:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [8*FETCH_BYTES-1:0] imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_icode,
    output logic [3:0]               out_ifun,
    output logic [3:0]               out_rA,
    output logic [3:0]               out_rB,
    output logic [63:0]              out_valC,
    output logic [63:0]              out_valP,
    output logic [63:0]              out_predPC,
    output logic [2:0]               out_stat
);

    localparam int unsigned OffW  = $clog2(FETCH_BYTES);
    localparam int unsigned CntW  = $clog2(BUF_BYTES + 1);
    localparam int unsigned Beats = BUF_BYTES / FETCH_BYTES;
    localparam int unsigned IfW   = $clog2(Beats + 1);
    localparam int unsigned DiscW = 8;
    localparam int unsigned BufW  = 8 * BUF_BYTES;

    localparam logic [63:0]     ImemEnd     = 64'(IMEM_SIZE);
    localparam logic [63:0]     AlignMask   = ~(64'(FETCH_BYTES) - 64'd1);
    localparam logic [CntW-1:0] FetchBytesC = CntW'(FETCH_BYTES);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [1:0] {StRun, StWaitRet, StHalted} state_e;

    // One extracted instruction; len is the number of buffer bytes it consumes.
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] predpc;
        logic [2:0]  stat;
        logic [3:0]  len;
    } rec_t;

    localparam rec_t RecReset = '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0,
                                  valp: 64'd0, predpc: 64'd0, stat: 3'd0, len: 4'd0};

    state_e          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [63:0]     fetch_addr_q, fetch_addr_d;
    logic [OffW-1:0] skip_q, skip_d;
    logic [BufW-1:0] buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IfW-1:0]  in_flight_q, in_flight_d;
    logic [DiscW-1:0] discard_q, discard_d;
    logic            out_valid_q, out_valid_d;
    rec_t            rec_q, rec_d;

    logic            hs, req_fire, rsp_take, rsp_drop;
    logic [31:0]     committed;
    logic [CntW-1:0] pop_len, cnt_pop, beat_len;
    logic [BufW-1:0] buf_pop;
    logic [8*FETCH_BYTES-1:0] beat_sh;
    logic            flush;
    logic [63:0]     flush_pc;

    logic [3:0]      d_icode, d_ifun, d_len;
    logic            d_has_regs, d_ins, d_adr, d_have, dec_valid;
    logic [63:0]     d_valc;
    logic [64:0]     d_end;
    rec_t            dec_rec;

    // ------------------------------------------------------------------------------------------
    // Memory request channel. Room is reserved for every beat still in flight so the buffer
    // cannot overflow whatever decode does.
    // ------------------------------------------------------------------------------------------
    always_comb begin
        committed      = 32'(cnt_q) + FETCH_BYTES * 32'(in_flight_q);
        imem_req_valid = !rst && (state_q == StRun) && (fetch_addr_q < ImemEnd) &&
                         (committed + FETCH_BYTES <= BUF_BYTES);
    end

    assign imem_req_addr = fetch_addr_q;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign hs            = out_valid_q && out_ready;
    // Beats that belong to a flushed stream are counted by discard_q and dropped.
    assign rsp_drop      = imem_rsp_valid && (discard_q != '0);
    assign rsp_take      = imem_rsp_valid && (discard_q == '0);

    // ------------------------------------------------------------------------------------------
    // Buffer, PC and control next state
    // ------------------------------------------------------------------------------------------
    always_comb begin
        // Byte 0 of the buffer is always the byte at pc_q; bytes at or above cnt_q are zero.
        pop_len  = hs ? CntW'(rec_q.len) : '0;
        cnt_pop  = cnt_q - pop_len;
        buf_pop  = buf_q >> {pop_len, 3'b000};
        beat_sh  = imem_rsp_data >> {skip_q, 3'b000};
        beat_len = FetchBytesC - CntW'(skip_q);

        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = req_fire ? fetch_addr_q + 64'(FETCH_BYTES) : fetch_addr_q;
        skip_d       = skip_q;
        in_flight_d  = in_flight_q + IfW'(req_fire) - IfW'(rsp_take);
        discard_d    = discard_q - DiscW'(rsp_drop);

        if (rsp_take) begin
            buf_d  = buf_pop | (BufW'(beat_sh) << {cnt_pop, 3'b000});
            cnt_d  = cnt_pop + beat_len;
            skip_d = '0;
        end else begin
            buf_d = buf_pop;
            cnt_d = cnt_pop;
        end

        flush    = 1'b0;
        flush_pc = rec_q.valc;
        if (hs) begin
            pc_d = rec_q.valp;
            if (rec_q.stat != StatAok) begin
                state_d = StHalted;
            end else if (rec_q.icode == 4'h9) begin
                state_d = StWaitRet;
            end else if (rec_q.icode == 4'h7 || rec_q.icode == 4'h8) begin
                flush = 1'b1;
            end
        end

        // An external redirect overrides any state change from a same-cycle handshake.
        if (redirect_valid) begin
            flush    = 1'b1;
            flush_pc = redirect_pc;
        end

        if (flush) begin
            state_d      = StRun;
            pc_d         = flush_pc;
            fetch_addr_d = flush_pc & AlignMask;
            skip_d       = flush_pc[OffW-1:0];
            buf_d        = '0;
            cnt_d        = '0;
            in_flight_d  = '0;
            // Everything still outstanding after this cycle (including a request accepted right
            // now) belongs to the old stream.
            discard_d    = discard_q - DiscW'(rsp_drop) + DiscW'(in_flight_q) +
                           DiscW'(req_fire) - DiscW'(rsp_take);
        end
    end

    // ------------------------------------------------------------------------------------------
    // Decode of the instruction at pc_d from the next buffer contents, so a new instruction is
    // presented the cycle after its last byte arrives or the previous one is popped.
    // ------------------------------------------------------------------------------------------
    always_comb begin
        d_icode    = buf_d[7:4];
        d_ifun     = buf_d[3:0];
        d_has_regs = 1'b0;
        d_ins      = 1'b0;
        d_valc     = '0;
        d_len      = 4'd1;
        case (d_icode)
            4'h0, 4'h1, 4'h9: d_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                d_len      = 4'd2;
                d_has_regs = 1'b1;
            end
            4'h3, 4'h4, 4'h5: begin
                d_len      = 4'd10;
                d_has_regs = 1'b1;
                d_valc     = buf_d[16 +: 64];
            end
            4'h7, 4'h8: begin
                d_len  = 4'd9;
                d_valc = buf_d[8 +: 64];
            end
            default: d_ins = 1'b1;
        endcase

        // 65-bit end address so a wrap past 2^64 is also caught as an address error.
        d_end     = {1'b0, pc_d} + 65'(d_len);
        d_adr     = (pc_d >= ImemEnd) || ((cnt_d != '0) && (d_end > {1'b0, ImemEnd}));
        d_have    = (cnt_d != '0) && (cnt_d >= CntW'(d_len));
        dec_valid = (state_d == StRun) && (d_adr || d_have);

        dec_rec = RecReset;
        if (d_adr) begin
            dec_rec.valp   = pc_d;
            dec_rec.predpc = pc_d;
            dec_rec.stat   = StatAdr;
            dec_rec.len    = 4'd0;
        end else begin
            dec_rec.icode = d_icode;
            dec_rec.ifun  = d_ifun;
            if (d_has_regs) begin
                dec_rec.ra = buf_d[15:12];
                dec_rec.rb = buf_d[11:8];
            end
            dec_rec.valc   = d_valc;
            dec_rec.valp   = d_end[63:0];
            dec_rec.predpc = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valc : d_end[63:0];
            dec_rec.len    = d_len;
            if (d_ins) begin
                dec_rec.stat = StatIns;
            end else if (d_icode == 4'h0) begin
                dec_rec.stat = StatHlt;
            end else begin
                dec_rec.stat = StatAok;
            end
        end
    end

    // Output register: held while decode stalls, dropped for one cycle on any flush.
    always_comb begin
        out_valid_d = out_valid_q;
        rec_d       = rec_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!(out_valid_q && !out_ready)) begin
            out_valid_d = dec_valid;
            if (dec_valid) begin
                rec_d = dec_rec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC & AlignMask;
            skip_q       <= RESET_PC[OffW-1:0];
            buf_q        <= '0;
            cnt_q        <= '0;
            in_flight_q  <= '0;
            discard_q    <= '0;
            out_valid_q  <= 1'b0;
            rec_q        <= RecReset;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            in_flight_q  <= in_flight_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            rec_q        <= rec_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_icode  = rec_q.icode;
    assign out_ifun   = rec_q.ifun;
    assign out_rA     = rec_q.ra;
    assign out_rB     = rec_q.rb;
    assign out_valC   = rec_q.valc;
    assign out_valP   = rec_q.valp;
    assign out_predPC = rec_q.predpc;
    assign out_stat   = rec_q.stat;

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Directed bench for y86_fetch_queue with a small in-order instruction memory model.

module tb_y86_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
    logic [63:0] out_valC, out_valP, out_predPC;
    logic [2:0]  out_stat;

    y86_fetch_queue #(
        .FETCH_BYTES(8),
        .BUF_BYTES  (32),
        .IMEM_SIZE  (1024),
        .RESET_PC   (64'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_icode     (out_icode),
        .out_ifun      (out_ifun),
        .out_rA        (out_rA),
        .out_rB        (out_rB),
        .out_valC      (out_valC),
        .out_valP      (out_valP),
        .out_predPC    (out_predPC),
        .out_stat      (out_stat)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    int vectors = 0;
    int miscompares = 0;

    // ---------------- memory model: sampled and driven on the falling edge ----------------
    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;
    req_t rq[$];
    int   ncyc = 0;
    int   lat = 2;

    function automatic logic [63:0] beat(input logic [63:0] a);
        logic [63:0] d = '0;
        logic [63:0] b;
        for (int i = 0; i < 8; i++) begin
            b = a + 64'(i);
            if (b < 64'd1024) d[i*8 +: 8] = mem[b[9:0]];
        end
        return d;
    endfunction

    initial begin
        req_t r;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                rq.delete();
            end else begin
                if (rq.size() > 0 && rq[0].due <= ncyc) begin
                    r = rq.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = beat(r.addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    r.addr = imem_req_addr;
                    r.due  = ncyc + lat;
                    rq.push_back(r);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
    logic [63:0] r_valc, r_valp, r_pred;
    logic [2:0]  r_stat;

    // Wait (bounded) for out_valid, capture the record, complete the handshake.
    task automatic get_rec(input string tag);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk($sformatf("%s valid", tag), 64'(out_valid), 64'd1);
        r_icode = out_icode;
        r_ifun  = out_ifun;
        r_ra    = out_rA;
        r_rb    = out_rB;
        r_valc  = out_valC;
        r_valp  = out_valP;
        r_pred  = out_predPC;
        r_stat  = out_stat;
        step();
    endtask

    task automatic chk_rec(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                           input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc,
                           input logic [63:0] valp, input logic [63:0] pred,
                           input logic [2:0] stat);
        chk($sformatf("%s icode", tag), 64'(r_icode), 64'(icode));
        chk($sformatf("%s ifun", tag), 64'(r_ifun), 64'(ifun));
        chk($sformatf("%s rA", tag), 64'(r_ra), 64'(ra));
        chk($sformatf("%s rB", tag), 64'(r_rb), 64'(rb));
        chk($sformatf("%s valC", tag), r_valc, valc);
        chk($sformatf("%s valP", tag), r_valp, valp);
        chk($sformatf("%s predPC", tag), r_pred, pred);
        chk($sformatf("%s stat", tag), 64'(r_stat), 64'(stat));
    endtask

    task automatic quiet(input string tag, input int n, input bit no_req);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s out_valid low", tag), 64'(out_valid), 64'd0);
            if (no_req) chk($sformatf("%s req low", tag), 64'(imem_req_valid), 64'd0);
            step();
        end
    endtask

    logic [63:0] h_valp;
    logic [15:0] h_fields;

    initial begin
        // ---------------- reset values + nop/halt stream ----------------
        fill_mem(8'h00);
        for (int i = 0; i < 10; i++) mem[i] = 8'h10;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        repeat (3) step();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst req_addr", imem_req_addr, 64'd0);
        chk("rst rA", 64'(out_rA), 64'hF);
        chk("rst rB", 64'(out_rB), 64'hF);
        chk("rst icode", 64'(out_icode), 64'd0);
        chk("rst valC", out_valC, 64'd0);
        chk("rst valP", out_valP, 64'd0);
        chk("rst predPC", out_predPC, 64'd0);
        chk("rst stat", 64'(out_stat), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            get_rec("nop");
            chk_rec($sformatf("nop%0d", k), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(k + 1),
                    64'(k + 1), 3'd1);
        end
        get_rec("halt");
        chk_rec("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 64'd11, 3'd2);
        quiet("halted", 20, 1'b1);

        // ---------------- irmovq ----------------
        fill_mem(8'h00);
        mem[0] = 8'h30;
        mem[1] = 8'hF2;
        for (int i = 0; i < 8; i++) mem[2 + i] = 8'(8 - i);
        do_reset();
        get_rec("irmovq");
        chk_rec("irmovq", 4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708, 64'd10, 64'd10, 3'd1);

        // ---------------- jmp at 5 ----------------
        fill_mem(8'h10);
        mem[5] = 8'h70;
        mem[6] = 8'h40;
        for (int i = 7; i < 14; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'h20;
        mem[8'h41] = 8'h12;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            get_rec("pre-jmp");
            chk($sformatf("pre-jmp%0d valP", k), r_valp, 64'(k + 1));
        end
        get_rec("jmp");
        chk_rec("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd14, 64'h40, 3'd1);
        get_rec("jmp dest");
        chk_rec("jmp dest", 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h42, 64'h42, 3'd1);

        // ---------------- ret then redirect ----------------
        fill_mem(8'h10);
        mem[0]     = 8'h90;
        mem[8'h20] = 8'h61;
        mem[8'h21] = 8'h23;
        do_reset();
        get_rec("ret");
        chk_rec("ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd1, 3'd1);
        quiet("wait_ret", 20, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        step();
        redirect_valid = 1'b0;
        chk("post-redirect out_valid", 64'(out_valid), 64'd0);
        get_rec("ret target");
        chk_rec("ret target", 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'h22, 64'h22, 3'd1);

        // ---------------- backpressure mid-stream ----------------
        fill_mem(8'h00);
        for (int k = 0; k < 64; k++) begin
            mem[2*k]     = 8'h20;
            mem[2*k + 1] = 8'(k);
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            get_rec("bp pre");
            chk($sformatf("bp%0d valP", k), r_valp, 64'(2*k + 2));
        end
        out_ready = 1'b0;
        for (int n = 0; n < 50 && !out_valid; n++) step();
        chk("bp hold valid", 64'(out_valid), 64'd1);
        h_valp   = out_valP;
        h_fields = {out_icode, out_ifun, out_rA, out_rB};
        for (int i = 0; i < 8; i++) begin
            step();
            chk("bp frozen valid", 64'(out_valid), 64'd1);
            chk("bp frozen valP", out_valP, h_valp);
            chk("bp frozen fields", 64'({out_icode, out_ifun, out_rA, out_rB}), 64'(h_fields));
        end
        chk("bp held valP", h_valp, 64'd8);
        for (int k = 3; k < 20; k++) begin
            get_rec("bp post");
            chk($sformatf("bp%0d valP", k), r_valp, 64'(2*k + 2));
            chk($sformatf("bp%0d rB", k), 64'(r_rb), 64'(k % 16));
            chk($sformatf("bp%0d rA", k), 64'(r_ra), 64'(k / 16));
        end

        // ---------------- ADR at 1020, then INS ----------------
        fill_mem(8'h00);
        mem[1020]  = 8'h30;
        mem[1021]  = 8'hF2;
        mem[1022]  = 8'h08;
        mem[1023]  = 8'h07;
        mem[12'h100] = 8'hC0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'd1020;
        step();
        redirect_valid = 1'b0;
        get_rec("adr");
        chk_rec("adr", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1020, 64'd1020, 3'd3);
        quiet("adr halted", 10, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        get_rec("ins");
        chk_rec("ins", 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, 64'h101, 3'd4);
        quiet("ins halted", 5, 1'b1);

        // ---------------- redirect with two beats in flight ----------------
        fill_mem(8'h10);
        mem[8'h80] = 8'h21;
        mem[8'h81] = 8'h45;
        lat = 6;
        do_reset();
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80;
        step();
        redirect_valid = 1'b0;
        chk("flush req_addr", imem_req_addr, 64'h80);
        chk("flush req_valid", 64'(imem_req_valid), 64'd1);
        imem_req_ready = 1'b1;
        get_rec("drop");
        chk_rec("drop", 4'h2, 4'h1, 4'h4, 4'h5, 64'd0, 64'h82, 64'h82, 3'd1);
        lat = 2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
